// File: rtl/bus_transfer_sequencer.sv
// Sequences one-hot bus-drive and load enables for the single-bit register cells
// on the shared tristate bus. It handles MOVE, SWAP (through a scratch register) and BROADCAST.
module bus_transfer_sequencer #(
  parameter int NUM_REGS = 8,
  parameter int IDX_W    = 3,
  parameter int TMP_IDX  = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          op,
  input  logic [IDX_W-1:0]    src,
  input  logic [IDX_W-1:0]    dst,
  output logic [NUM_REGS-1:0] r_out,
  output logic [NUM_REGS-1:0] r_in,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam logic [1:0]       OP_MOVE  = 2'b00;
  localparam logic [1:0]       OP_SWAP  = 2'b01;
  localparam logic [1:0]       OP_BCAST = 2'b10;
  localparam logic [IDX_W-1:0] TMP      = IDX_W'(TMP_IDX);

  typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;

  state_t                state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [IDX_W-1:0]      src_q, src_d;
  logic [IDX_W-1:0]      dst_q, dst_d;
  logic [NUM_REGS-1:0]   r_out_q, r_out_d;
  logic [NUM_REGS-1:0]   r_in_q, r_in_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  src_bad, dst_bad, illegal;

  // An out-of-range index shifts the single set bit off the top, so it yields no enable
  function automatic logic [NUM_REGS-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot = {{(NUM_REGS-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Indices are compared at full width against the register count, so nothing wraps
  always_comb begin
    src_bad = 32'(src) >= NUM_REGS;
    dst_bad = 32'(dst) >= NUM_REGS;
    illegal = 1'b0;
    case (op)
      OP_MOVE:  illegal = src_bad || dst_bad || (src == dst);
      OP_SWAP:  illegal = src_bad || dst_bad || (src == dst) || (src == TMP) || (dst == TMP);
      OP_BCAST: illegal = src_bad;
      default:  illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    src_d   = src_q;
    dst_d   = dst_q;
    r_out_d = '0;
    r_in_d  = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (illegal) begin
            err_d = 1'b1;
          end else begin
            op_d    = op;
            src_d   = src;
            dst_d   = dst;
            state_d = T1;
            r_out_d = onehot(src);
            if (op == OP_BCAST)     r_in_d = ~onehot(src);
            else if (op == OP_SWAP) r_in_d = onehot(TMP);
            else                    r_in_d = onehot(dst);
          end
        end
      end
      T1: begin
        if (op_q == OP_SWAP) begin
          state_d = T2;
          r_out_d = onehot(dst_q);
          r_in_d  = onehot(src_q);
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      T2: begin
        state_d = T3;
        r_out_d = onehot(TMP);
        r_in_d  = onehot(dst_q);
      end
      default: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      r_out_q <= '0;
      r_in_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      r_out_q <= r_out_d;
      r_in_q  <= r_in_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign r_out     = r_out_q;
  assign r_in      = r_in_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = (state_q != IDLE);
  assign req_ready = (state_q == IDLE);

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Directed bench for bus_transfer_sequencer. A bit-level register bank model is attached to
// the enables, and bus invariants are checked on every clock.
module tb_bus_transfer_sequencer;

  logic       clk;
  logic       reset;
  logic       req_valid, req_ready, busy, done, err;
  logic [1:0] op;
  logic [2:0] src, dst;
  logic [7:0] r_out, r_in;

  logic       req_valid2, req_ready2, busy2, done2, err2;
  logic [1:0] op2;
  logic [2:0] src2, dst2;
  logic [5:0] r_out2, r_in2;

  logic [7:0] bank, bank_init;
  logic       bank_load;
  logic       bus;

  int checks = 0;
  int errors = 0;

  bus_transfer_sequencer #(.NUM_REGS(8), .IDX_W(3), .TMP_IDX(7)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .op(op), .src(src), .dst(dst), .r_out(r_out), .r_in(r_in),
    .busy(busy), .done(done), .err(err)
  );

  bus_transfer_sequencer #(.NUM_REGS(6), .IDX_W(3), .TMP_IDX(5)) dut6 (
    .clk(clk), .reset(reset), .req_valid(req_valid2), .req_ready(req_ready2),
    .op(op2), .src(src2), .dst(dst2), .r_out(r_out2), .r_in(r_in2),
    .busy(busy2), .done(done2), .err(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank of single-bit register cells on the shared bus
  assign bus = |(r_out & bank);
  always @(posedge clk) begin
    if (bank_load) bank <= bank_init;
    else for (int i = 0; i < 8; i++) if (r_in[i]) bank[i] <= bus;
  end

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance one clock, then check the bus invariants away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
    chk1("inv_onehot_out", $countones(r_out) <= 1, 1'b1);
    chk8("inv_in_and_out", r_in & r_out, 8'h00);
    chk1("inv_done_err", done & err, 1'b0);
    chk1("inv_busy_ready", busy, ~req_ready);
    if (req_ready) chk8("inv_idle_quiet", r_out | r_in, 8'h00);
  endtask

  task automatic req(input logic [1:0] o, input logic [2:0] s, input logic [2:0] d);
    req_valid = 1'b1;
    op        = o;
    src       = s;
    dst       = d;
  endtask

  task automatic check_illegal(input string tag);
    tick();
    req_valid = 1'b0;
    chk1({tag, "_err"}, err, 1'b1);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_ready"}, req_ready, 1'b1);
    chk1({tag, "_done"}, done, 1'b0);
    chk8({tag, "_out"}, r_out, 8'h00);
    chk8({tag, "_in"}, r_in, 8'h00);
    tick();
    chk1({tag, "_err_clr"}, err, 1'b0);
    chk1({tag, "_no_done"}, done, 1'b0);
  endtask

  initial begin
    reset      = 1'b0;
    req_valid  = 1'b0;
    op         = 2'b00;
    src        = 3'd0;
    dst        = 3'd0;
    req_valid2 = 1'b0;
    op2        = 2'b00;
    src2       = 3'd0;
    dst2       = 3'd0;
    bank_load  = 1'b0;
    bank_init  = 8'h00;

    #12;
    chk8("rst_out", r_out, 8'h00);
    chk8("rst_in", r_in, 8'h00);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_ready", req_ready, 1'b1);
    reset = 1'b1;
    tick();

    // MOVE 2 -> 5
    req(2'b00, 3'd2, 3'd5);
    tick();
    req_valid = 1'b0;
    chk8("mv_out", r_out, 8'h04);
    chk8("mv_in", r_in, 8'h20);
    chk1("mv_busy", busy, 1'b1);
    chk1("mv_ready", req_ready, 1'b0);
    chk1("mv_done_early", done, 1'b0);
    tick();
    chk1("mv_done", done, 1'b1);
    chk8("mv_out_idle", r_out, 8'h00);
    chk8("mv_in_idle", r_in, 8'h00);
    chk1("mv_ready_done", req_ready, 1'b1);
    tick();
    chk1("mv_done_pulse", done, 1'b0);

    // SWAP 1 <-> 3 with reg1=1, reg3=0
    bank_init = 8'b0000_0010;
    bank_load = 1'b1;
    tick();
    bank_load = 1'b0;
    req(2'b01, 3'd1, 3'd3);
    tick();
    req_valid = 1'b0;
    chk8("sw_t1_out", r_out, 8'h02);
    chk8("sw_t1_in", r_in, 8'h80);
    tick();
    chk8("sw_t2_out", r_out, 8'h08);
    chk8("sw_t2_in", r_in, 8'h02);
    chk1("sw_t2_busy", busy, 1'b1);
    tick();
    chk8("sw_t3_out", r_out, 8'h80);
    chk8("sw_t3_in", r_in, 8'h08);
    chk1("sw_t3_done", done, 1'b0);
    tick();
    chk1("sw_done", done, 1'b1);
    chk1("sw_ready", req_ready, 1'b1);
    chk1("sw_reg1", bank[1], 1'b0);
    chk1("sw_reg3", bank[3], 1'b1);
    tick();

    // BROADCAST from 0
    req(2'b10, 3'd0, 3'd6);
    tick();
    req_valid = 1'b0;
    chk8("bc_out", r_out, 8'h01);
    chk8("bc_in", r_in, 8'hFE);
    tick();
    chk1("bc_done", done, 1'b1);
    tick();

    // Illegal requests
    req(2'b00, 3'd4, 3'd4);
    check_illegal("il_mv_same");
    req(2'b01, 3'd2, 3'd7);
    check_illegal("il_sw_dst_tmp");
    req(2'b01, 3'd7, 3'd2);
    check_illegal("il_sw_src_tmp");
    req(2'b11, 3'd0, 3'd1);
    check_illegal("il_op11");

    // Six-register instance: index 6 does not exist
    req_valid2 = 1'b1;
    op2        = 2'b00;
    src2       = 3'd6;
    dst2       = 3'd1;
    tick();
    req_valid2 = 1'b0;
    chk1("n6_err", err2, 1'b1);
    chk1("n6_busy", busy2, 1'b0);
    chk8("n6_out", {2'b00, r_out2}, 8'h00);
    chk8("n6_in", {2'b00, r_in2}, 8'h00);
    tick();
    chk1("n6_no_done", done2, 1'b0);
    chk1("n6_err_clr", err2, 1'b0);

    // Back-to-back with req_valid held high
    req(2'b00, 3'd0, 3'd1);
    tick();
    chk8("bb1_out", r_out, 8'h01);
    chk8("bb1_in", r_in, 8'h02);
    req(2'b00, 3'd1, 3'd2);
    tick();
    chk1("bb1_done", done, 1'b1);
    chk8("bb1_out_idle", r_out, 8'h00);
    tick();
    req_valid = 1'b0;
    chk1("bb2_done_clr", done, 1'b0);
    chk8("bb2_out", r_out, 8'h02);
    chk8("bb2_in", r_in, 8'h04);
    tick();
    chk1("bb2_done", done, 1'b1);
    tick();

    // Asynchronous reset in the middle of a SWAP (T2)
    req(2'b01, 3'd1, 3'd3);
    tick();
    req_valid = 1'b0;
    tick();
    chk8("ar_t2_out", r_out, 8'h08);
    #2;
    reset = 1'b0;
    #1;
    chk8("ar_out", r_out, 8'h00);
    chk8("ar_in", r_in, 8'h00);
    chk1("ar_busy", busy, 1'b0);
    chk1("ar_done", done, 1'b0);
    chk1("ar_err", err, 1'b0);
    chk1("ar_ready", req_ready, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    chk1("ar_post_done", done, 1'b0);
    chk1("ar_post_ready", req_ready, 1'b1);
    tick();
    chk1("ar_post_done2", done, 1'b0);
    chk8("ar_post_out", r_out, 8'h00);

    // Random request stream, invariants checked each cycle
    for (int n = 0; n < 300; n++) begin
      req_valid = 1'($urandom_range(0, 1));
      op        = 2'($urandom_range(0, 3));
      src       = 3'($urandom_range(0, 7));
      dst       = 3'($urandom_range(0, 7));
      tick();
    end
    req_valid = 1'b0;
    tick();
    tick();
    tick();
    tick();
    chk1("rnd_drain_ready", req_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
